regfile_wport_sched: RTL

- Schedules the single write port (we3/wa3/wd3) of the 32x32 GPR file between two writers:
  - the in-order pipeline writeback stage, which has priority and no backpressure;
  - the return path of a long-latency unit (LU: multi-cycle multiply/divide-to-GPR, CP0 moves), which uses a valid/ready handshake through a small queue.
- Keeps a pending-write scoreboard for LU destinations and raises decode-stage stalls on RAW/WAW hazards.
- Sits between writeback, the LU and the register file.

---
 rtl/regfile_wport_sched_if.sv | 38 +++
 rtl/regfile_wport_sched.sv | 115 +++++++++++
 2 files changed

// File: rtl/regfile_wport_sched_if.sv
// Bundle of writeback, LU return, decode hazard and register-file write
// signals that connect the write-port scheduler to the pipeline.
interface regfile_wport_sched_if;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        lu_issue_valid;
   logic [4:0]  lu_issue_wa;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_wa;
   logic [31:0] lu_wd;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        dst_valid;
   logic [4:0]  dst_wa;
   logic        raw_stall;
   logic        issue_stall;
   logic        wb_hold;
   logic        rf_we3;
   logic [4:0]  rf_wa3;
   logic [31:0] rf_wd3;
   logic [31:0] busy_vec;

   modport master (
      output wb_we, wb_wa, wb_wd, lu_issue_valid, lu_issue_wa,
             lu_valid, lu_wa, lu_wd, ra1, ra2, dst_valid, dst_wa,
      input  lu_ready, raw_stall, issue_stall, wb_hold,
             rf_we3, rf_wa3, rf_wd3, busy_vec
   );

   modport slave (
      input  wb_we, wb_wa, wb_wd, lu_issue_valid, lu_issue_wa,
             lu_valid, lu_wa, lu_wd, ra1, ra2, dst_valid, dst_wa,
      output lu_ready, raw_stall, issue_stall, wb_hold,
             rf_we3, rf_wa3, rf_wd3, busy_vec
   );
endinterface

// File: rtl/regfile_wport_sched.sv
// GPR write-port scheduler: writeback has priority, long-latency results
// go through a small FIFO (or bypass it when the port is idle), and a
// pending-write scoreboard drives decode RAW/WAW stalls.
module regfile_wport_sched #(
   parameter int QDEPTH     = 2,
   parameter int STARVE_LIM = 4
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wport_sched_if.slave bus
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(STARVE_LIM + 2);

   logic [4:0]    q_wa [QDEPTH];
   logic [31:0]   q_wd [QDEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   q_cnt;
   logic [CW-1:0] starve_cnt;
   logic [31:0]   busy;
   logic [31:0]   busy_next;

   logic        q_empty, q_full, ready;
   logic        wb_sel, q_sel, byp_sel;
   logic        push, pop, lu_wr, wr_en, set_en, iss;
   logic [4:0]  sel_wa;
   logic [31:0] sel_wd;

   assign q_empty = (q_cnt == '0);
   assign q_full  = (q_cnt == (AW+1)'(QDEPTH));
   assign ready   = !rst && !q_full;

   // a writeback to $0 does not claim the port, so LU traffic may use it
   assign wb_sel  = bus.wb_we && (bus.wb_wa != 5'd0);
   assign q_sel   = !wb_sel && !q_empty;
   assign byp_sel = !wb_sel && q_empty && bus.lu_valid && ready;
   assign push    = bus.lu_valid && ready && !byp_sel;
   assign pop     = q_sel && !rst;
   assign lu_wr   = !rst && (q_sel || byp_sel);

   // source mux for the write port
   always_comb begin
      sel_wa = 5'd0;
      sel_wd = 32'd0;
      if (wb_sel) begin
         sel_wa = bus.wb_wa;
         sel_wd = bus.wb_wd;
      end else if (q_sel) begin
         sel_wa = q_wa[rd_ptr];
         sel_wd = q_wd[rd_ptr];
      end else if (byp_sel) begin
         sel_wa = bus.lu_wa;
         sel_wd = bus.lu_wd;
      end
   end

   assign wr_en  = !rst && (wb_sel || (lu_wr && (sel_wa != 5'd0)));
   assign iss    = !rst && bus.lu_issue_valid && busy[bus.lu_issue_wa];
   assign set_en = !rst && bus.lu_issue_valid && (bus.lu_issue_wa != 5'd0) && !iss;

   // scoreboard next state: clear on LU commit, then set so set wins
   always_comb begin
      busy_next = busy;
      if (lu_wr) busy_next[sel_wa] = 1'b0;
      if (set_en) busy_next[bus.lu_issue_wa] = 1'b1;
      busy_next[0] = 1'b0;
   end

   assign bus.lu_ready    = ready;
   assign bus.rf_we3      = wr_en;
   assign bus.rf_wa3      = wr_en ? sel_wa : 5'd0;
   assign bus.rf_wd3      = wr_en ? sel_wd : 32'd0;
   assign bus.issue_stall = iss;
   assign bus.wb_hold     = !rst && (starve_cnt == CW'(STARVE_LIM));
   assign bus.busy_vec    = rst ? 32'd0 : busy;
   assign bus.raw_stall   = !rst && (((bus.ra1 != 5'd0) && busy[bus.ra1]) ||
                                     ((bus.ra2 != 5'd0) && busy[bus.ra2]) ||
                                     (bus.dst_valid && (bus.dst_wa != 5'd0) && busy[bus.dst_wa]));

   // queue payload storage; contents are don't-care while unoccupied
   always_ff @(posedge clk) begin
      if (push) begin
         q_wa[wr_ptr] <= bus.lu_wa;
         q_wd[wr_ptr] <= bus.lu_wd;
      end
   end

   // queue pointers, occupancy, starvation counter and scoreboard
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         q_cnt      <= '0;
         starve_cnt <= '0;
         busy       <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + (AW+1)'(1);
            2'b01:   q_cnt <= q_cnt - (AW+1)'(1);
            default: q_cnt <= q_cnt;
         endcase
         // saturate one past the limit so wb_hold stays a single pulse
         if (!q_empty && wb_sel) begin
            if (starve_cnt != CW'(STARVE_LIM + 1))
               starve_cnt <= starve_cnt + CW'(1);
         end else begin
            starve_cnt <= '0;
         end
         busy <= busy_next;
      end
   end
endmodule
